trap_sequencer: RTL

Multi-cycle controller that sequences machine-mode interrupt entry and `mret` return for the pipelined Otter core. It watches the EX stage, stalls fetch, waits for any in-flight memory access to drain, and issues the CSR update pulses. It then flushes IF/ID/EX and redirects the PC to `mtvec` or `mepc`. It sits beside the hazard unit, consumes the decoder's `mret` flag as pipelined into EX, and drives the CSR file's trap/return strobes.

---
 rtl/trap_sequencer_pkg.sv | 16 +
 rtl/trap_sequencer_sat_counter.sv | 19 +
 rtl/trap_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
package otter_trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    TRAP,
    MRET,
    REDIRECT
  } trap_state_t;

  localparam logic [31:0] MCAUSE_EXT_IRQ   = 32'h8000_000B;
  // Direct-mode vectoring only: the low two mtvec bits are the mode field.
  localparam logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/trap_sequencer_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences interrupt entry and mret return: stalls fetch, drains memory,
// pulses the CSR strobes, then flushes and redirects the PC.
module trap_sequencer
  import otter_trap_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] MCAUSE_EXT = MCAUSE_EXT_IRQ
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             mret_ex,
  input  logic             intr,
  input  logic             mie,
  input  logic             mem_busy,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  output logic             stall_if,
  output logic             flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             csr_trap_we,
  output logic [31:0]      mepc_wdata,
  output logic [31:0]      mcause_wdata,
  output logic             mstatus_trap,
  output logic             mstatus_mret,
  output logic             busy,
  output logic [CNT_W-1:0] trap_cnt
);

  trap_state_t state;
  logic [31:0] epc;
  logic [31:0] target;

  // Outputs are registered alongside the state so each reflects the state
  // being entered; nothing reaches an output combinationally from an input.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      epc          <= '0;
      target       <= '0;
      stall_if     <= 1'b0;
      flush        <= 1'b0;
      pc_redirect  <= 1'b0;
      csr_trap_we  <= 1'b0;
      mstatus_trap <= 1'b0;
      mstatus_mret <= 1'b0;
      busy         <= 1'b0;
    end else begin
      stall_if     <= 1'b0;
      flush        <= 1'b0;
      pc_redirect  <= 1'b0;
      csr_trap_we  <= 1'b0;
      mstatus_trap <= 1'b0;
      mstatus_mret <= 1'b0;
      busy         <= 1'b0;
      case (state)
        IDLE: begin
          // mret takes priority; a pending interrupt is re-evaluated once MIE is restored.
          if (ex_valid && mret_ex) begin
            state        <= MRET;
            mstatus_mret <= 1'b1;
            flush        <= 1'b1;
            stall_if     <= 1'b1;
            busy         <= 1'b1;
          end else if (ex_valid && intr && mie) begin
            state    <= DRAIN;
            epc      <= ex_pc;
            stall_if <= 1'b1;
            busy     <= 1'b1;
          end
        end
        DRAIN: begin
          stall_if <= 1'b1;
          busy     <= 1'b1;
          if (!mem_busy) begin
            state        <= TRAP;
            csr_trap_we  <= 1'b1;
            mstatus_trap <= 1'b1;
            flush        <= 1'b1;
          end
        end
        TRAP: begin
          state       <= REDIRECT;
          target      <= mtvec & MTVEC_ALIGN_MASK;
          pc_redirect <= 1'b1;
          flush       <= 1'b1;
          stall_if    <= 1'b1;
          busy        <= 1'b1;
        end
        MRET: begin
          state       <= REDIRECT;
          target      <= mepc & MTVEC_ALIGN_MASK;
          pc_redirect <= 1'b1;
          flush       <= 1'b1;
          stall_if    <= 1'b1;
          busy        <= 1'b1;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign redirect_pc  = target;
  assign mepc_wdata   = epc;
  assign mcause_wdata = MCAUSE_EXT;

  sat_counter #(.W(CNT_W)) u_trap_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (state == TRAP),
    .count (trap_cnt)
  );

endmodule
